fifo_state_machine: RTL and testbench
=====================================

# fifo_state_machine

Parametrised control FSM for the transaction-layer FIFO bank. It tracks NUM_FIFOS FIFO empty/error flags through RESET → INIT → IDLE → ACTIVE → ERROR. It captures per-FIFO thresholds during INIT. It returns from ACTIVE to IDLE after a programmable run of all-empty cycles. It records which FIFOs raised the error that caused entry to ERROR.

## Interface
- NUM_FIFOS, default 5: number of FIFOs monitored (main, VC0, VC1, D0, D1); minimum 1.
- TH_W, default 4: threshold width per FIFO.
- IDLE_HOLD, default 4: consecutive all-empty cycles in ACTIVE before returning to IDLE; minimum 1.
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  leave INIT, enter IDLE.
- thresholds  in  NUM_FIFOS*TH_W  packed thresholds; FIFO i occupies bits [i*TH_W +: TH_W].
- empty  in  NUM_FIFOS  per-FIFO empty flags.
- error  in  NUM_FIFOS  per-FIFO overflow/underflow error flags.
- err_clr  in  1  error acknowledge; used only with SM_ERR_CLEAR_EN.
- thresholds_out  out  NUM_FIFOS*TH_W  registered captured thresholds.
- present_state  out  4  registered one-hot state.
- next_state  out  4  combinational next state.
- idle_out, active_out, error_out  out  1 each  registered state flags.
- err_src  out  NUM_FIFOS  registered error-source bits.

## Operation
- State encodings: RESET=4'b0000, INIT=4'b0001, IDLE=4'b0010, ACTIVE=4'b0100, ERROR=4'b1000. Any other value goes to RESET.
- reset=1 overrides everything. On the next edge: present_state=RESET, all flags 0, err_src=0, thresholds_out=0, hold counter 0.
- RESET: with reset=0, go to INIT.
- INIT:
  - init=0: thresholds_out <= thresholds every cycle; stay in INIT.
  - init=1: go to IDLE; no capture on that cycle.
- IDLE:
  - Priority 1: any error bit set → ERROR.
  - Priority 2: any empty bit clear → ACTIVE.
  - Otherwise stay in IDLE.
- ACTIVE:
  - Any error bit set → ERROR; this takes priority over the idle return.
  - Hold counter increments on each cycle with all empty bits set. It clears on any cycle with a non-empty FIFO.
  - When the counter reaches IDLE_HOLD, go to IDLE and clear the counter.
  - Counter width: $clog2(IDLE_HOLD+1). It saturates and never wraps.
- ERROR:
  - On entry: err_src <= error.
  - While in ERROR: err_src <= err_src | error, so sources accumulate.
  - Exits only by reset, unless the configuration feature below is compiled in.
- Flags track present_state: idle_out=(state==IDLE), active_out=(state==ACTIVE), error_out=(state==ERROR). They are updated on the same edge as the state.
- thresholds_out holds its value in all states except INIT and reset.

## Timing
- All outputs except next_state are registered; next_state is valid in the same cycle as its inputs.
- State-transition latency is 1 cycle from the sampled condition.
- From deassertion of reset to IDLE takes at least 2 edges: RESET→INIT, then INIT→IDLE with init=1.
- Return to IDLE happens IDLE_HOLD cycles after empty becomes all-ones in ACTIVE, counted from the first all-empty sampled edge.
- error and all-empty sampled together in ACTIVE: go to ERROR; the counter clears.
- reset during ACTIVE or ERROR: RESET on the next edge; the error-source history is lost.

## Configuration
- SM_ERR_CLEAR_EN defined:
  - In ERROR, err_clr=1 → INIT on the next edge, with err_src=0 and error_out=0.
  - Thresholds are then recaptured in INIT.
  - If err_clr and a new error are sampled on the same edge, the clear wins.
- SM_ERR_CLEAR_EN undefined: err_clr is ignored and ERROR is left only through reset.

## Structure
- state_machine_pkg holds the state encoding localparams and a state_t 4-bit typedef. It is shared with the FIFO bank and the bench.
- One sub-module, empty_hold_counter, contains the IDLE_HOLD saturating counter. It has inputs en, clr, all_empty and output done.
- The FSM core stays in fifo_state_machine.

## Test plan
- Reset flow: reset=1 for 2 cycles, then 0 with init=0. Required: state 0000 → 0001, thresholds_out follows thresholds=0x12345, all flags 0.
- Init capture: in INIT with thresholds=0xABCDE, assert init. Required: IDLE next edge, thresholds_out stays 0xABCDE after thresholds changes to 0.
- Activity: in IDLE with empty=5'b11111, drive empty=5'b11011. Required: ACTIVE next edge, active_out=1, idle_out=0. Then empty=5'b11111 for 4 cycles → IDLE on the 4th edge; a glitch back to 5'b11011 at cycle 3 restarts the count.
- Error capture: in ACTIVE drive error=5'b00100 for 1 cycle, then 5'b00001. Required: ERROR, err_src=5'b00100, then 5'b00101; error_out=1.
- Error exit: with SM_ERR_CLEAR_EN, err_clr=1 in ERROR → INIT with err_src=0. Without it, stay in ERROR until reset=1 → RESET.
- Simultaneous: in IDLE, error=5'b10000 with empty=5'b01111 on the same cycle → ERROR, not ACTIVE.

Source files
------------

// File: rtl/state_machine_pkg.sv
// Shared state encoding for the FIFO bank control FSM.
package state_machine_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] STATE_RESET  = 4'b0000;
  localparam logic [STATE_W-1:0] STATE_INIT   = 4'b0001;
  localparam logic [STATE_W-1:0] STATE_IDLE   = 4'b0010;
  localparam logic [STATE_W-1:0] STATE_ACTIVE = 4'b0100;
  localparam logic [STATE_W-1:0] STATE_ERROR  = 4'b1000;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = STATE_RESET,
    ST_INIT   = STATE_INIT,
    ST_IDLE   = STATE_IDLE,
    ST_ACTIVE = STATE_ACTIVE,
    ST_ERROR  = STATE_ERROR
  } state_t;

endpackage

// File: rtl/empty_hold_counter.sv
// Saturating count of consecutive all-empty cycles while ACTIVE.
// done fires combinationally on the cycle whose edge completes IDLE_HOLD cycles.
module empty_hold_counter #(
  parameter int unsigned IDLE_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic all_empty,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(IDLE_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IDLE_HOLD);

  logic [CNT_W-1:0] cnt;

  // Final all-empty cycle of the run is the one that would bring cnt to IDLE_HOLD.
  assign done = en && all_empty && (cnt == CNT_LAST);

  // Count all-empty cycles; any busy cycle or external clear restarts the run.
  always_ff @(posedge clk) begin
    if (reset || clr || !en || !all_empty) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_state_machine.sv
// Control FSM for the transaction-layer FIFO bank.
// Optional feature: define SM_ERR_CLEAR_EN to allow err_clr to leave ERROR for INIT.
module fifo_state_machine
  import state_machine_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = 5,
  parameter int unsigned TH_W      = 4,
  parameter int unsigned IDLE_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [NUM_FIFOS*TH_W-1:0] thresholds,
  input  logic [NUM_FIFOS-1:0]      empty,
  input  logic [NUM_FIFOS-1:0]      error,
  input  logic                      err_clr,
  output logic [NUM_FIFOS*TH_W-1:0] thresholds_out,
  output logic [STATE_W-1:0]        present_state,
  output logic [STATE_W-1:0]        next_state,
  output logic                      idle_out,
  output logic                      active_out,
  output logic                      error_out,
  output logic [NUM_FIFOS-1:0]      err_src
);

  state_t state_q;
  state_t state_d;
  logic   all_empty;
  logic   any_err;
  logic   hold_done;
  logic   hold_en;
  logic   hold_clr;

  assign all_empty     = &empty;
  assign any_err       = |error;
  assign hold_en       = (state_q == ST_ACTIVE);
  assign hold_clr      = (state_d != ST_ACTIVE);
  assign present_state = state_q;
  assign next_state    = state_d;

`ifndef SM_ERR_CLEAR_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  empty_hold_counter #(
    .IDLE_HOLD (IDLE_HOLD)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .en        (hold_en),
    .clr       (hold_clr),
    .all_empty (all_empty),
    .done      (hold_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; errors outrank both activity and the idle return.
  always_comb begin
    state_d = ST_RESET;
    if (!reset) begin
      case (state_q)
        ST_RESET:  state_d = ST_INIT;
        ST_INIT:   state_d = init ? ST_IDLE : ST_INIT;
        ST_IDLE: begin
          if (any_err)         state_d = ST_ERROR;
          else if (!all_empty) state_d = ST_ACTIVE;
          else                 state_d = ST_IDLE;
        end
        ST_ACTIVE: begin
          if (any_err)        state_d = ST_ERROR;
          else if (hold_done) state_d = ST_IDLE;
          else                state_d = ST_ACTIVE;
        end
        ST_ERROR: begin
`ifdef SM_ERR_CLEAR_EN
          state_d = err_clr ? ST_INIT : ST_ERROR;
`else
          state_d = ST_ERROR;
`endif
        end
        default:   state_d = ST_RESET;
      endcase
    end
  end

  // Registered flags, threshold capture and error-source history.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_out       <= 1'b0;
      active_out     <= 1'b0;
      error_out      <= 1'b0;
      err_src        <= '0;
      thresholds_out <= '0;
    end else begin
      idle_out   <= (state_d == ST_IDLE);
      active_out <= (state_d == ST_ACTIVE);
      error_out  <= (state_d == ST_ERROR);

      if ((state_q == ST_INIT) && !init) begin
        thresholds_out <= thresholds;
      end

      if (state_d == ST_ERROR) begin
        err_src <= (state_q == ST_ERROR) ? (err_src | error) : error;
      end else if (state_q == ST_ERROR) begin
        err_src <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_state_machine.sv
// Self-checking bench for fifo_state_machine: directed steps then random traffic.
module tb_fifo_state_machine;
  import state_machine_pkg::*;

  localparam int unsigned NF = 5;
  localparam int unsigned TW = 4;
  localparam int unsigned IH = 4;
  localparam int unsigned TB = NF * TW;

  logic          clk;
  logic          reset;
  logic          init;
  logic [TB-1:0] thresholds;
  logic [NF-1:0] empty;
  logic [NF-1:0] error;
  logic          err_clr;
  logic [TB-1:0] thresholds_out;
  logic [3:0]    present_state;
  logic [3:0]    next_state;
  logic          idle_out;
  logic          active_out;
  logic          error_out;
  logic [NF-1:0] err_src;

  fifo_state_machine #(
    .NUM_FIFOS (NF),
    .TH_W      (TW),
    .IDLE_HOLD (IH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .thresholds     (thresholds),
    .empty          (empty),
    .error          (error),
    .err_clr        (err_clr),
    .thresholds_out (thresholds_out),
    .present_state  (present_state),
    .next_state     (next_state),
    .idle_out       (idle_out),
    .active_out     (active_out),
    .error_out      (error_out),
    .err_src        (err_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: state, length of current all-empty run, error history, thresholds.
  logic [3:0]    m_st  = STATE_RESET;
  int            m_run = 0;
  logic [NF-1:0] m_err = '0;
  logic [TB-1:0] m_thr = '0;

  logic [3:0]    p_st;
  int            p_run;
  logic [NF-1:0] p_err;
  logic [TB-1:0] p_thr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic predict();
    logic all_e;
    all_e = (empty == {NF{1'b1}});
    p_st = m_st; p_run = m_run; p_err = m_err; p_thr = m_thr;
    if (reset) begin
      p_st = STATE_RESET; p_run = 0; p_err = '0; p_thr = '0;
    end else begin
      case (m_st)
        STATE_RESET: p_st = STATE_INIT;
        STATE_INIT: begin
          if (init) p_st = STATE_IDLE;
          else      p_thr = thresholds;
        end
        STATE_IDLE: begin
          if (error != '0) begin
            p_st = STATE_ERROR; p_err = error;
          end else if (!all_e) begin
            p_st = STATE_ACTIVE; p_run = 0;
          end
        end
        STATE_ACTIVE: begin
          if (error != '0) begin
            p_st = STATE_ERROR; p_err = error; p_run = 0;
          end else if (all_e) begin
            p_run = m_run + 1;
            if (p_run >= int'(IH)) begin
              p_st = STATE_IDLE; p_run = 0;
            end
          end else begin
            p_run = 0;
          end
        end
        STATE_ERROR: begin
`ifdef SM_ERR_CLEAR_EN
          if (err_clr) begin
            p_st = STATE_INIT; p_err = '0;
          end else begin
            p_err = m_err | error;
          end
`else
          p_err = m_err | error;
`endif
        end
        default: p_st = STATE_RESET;
      endcase
    end
  endtask

  // One cycle: drive, check combinational next_state, clock, check registered outputs.
  task automatic step(input logic r, input logic i, input logic [TB-1:0] th,
                      input logic [NF-1:0] em, input logic [NF-1:0] er, input logic ec);
    reset = r; init = i; thresholds = th; empty = em; error = er; err_clr = ec;
    #1;
    predict();
    chk("next_state", 32'(next_state), 32'(p_st));
    @(posedge clk);
    #1;
    m_st = p_st; m_run = p_run; m_err = p_err; m_thr = p_thr;
    chk("present_state", 32'(present_state), 32'(m_st));
    chk("idle_out", 32'(idle_out), 32'(m_st == STATE_IDLE));
    chk("active_out", 32'(active_out), 32'(m_st == STATE_ACTIVE));
    chk("error_out", 32'(error_out), 32'(m_st == STATE_ERROR));
    chk("err_src", 32'(err_src), 32'(m_err));
    chk("thresholds_out", 32'(thresholds_out), 32'(m_thr));
  endtask

  localparam logic [NF-1:0] ALL_E = 5'b11111;
  localparam logic [NF-1:0] BUSY  = 5'b11011;

  initial begin
    reset = 1'b1; init = 1'b0; thresholds = '0; empty = ALL_E; error = '0; err_clr = 1'b0;
    @(posedge clk);
    #1;

    // Reset flow and INIT capture.
    step(1, 0, 20'h12345, ALL_E, '0, 0);
    step(1, 0, 20'h12345, ALL_E, '0, 0);
    chk("reset_state", 32'(present_state), 32'(STATE_RESET));
    step(0, 0, 20'h12345, ALL_E, '0, 0);
    chk("reset_to_init", 32'(present_state), 32'(STATE_INIT));
    step(0, 0, 20'h12345, ALL_E, '0, 0);
    chk("init_capture", 32'(thresholds_out), 32'h12345);
    step(0, 0, 20'hABCDE, ALL_E, '0, 0);
    step(0, 1, 20'hABCDE, ALL_E, '0, 0);
    chk("init_to_idle", 32'(present_state), 32'(STATE_IDLE));
    step(0, 0, 20'h00000, ALL_E, '0, 0);
    chk("thr_held", 32'(thresholds_out), 32'hABCDE);

    // Activity, glitch restart, then return to IDLE on the 4th all-empty edge.
    step(0, 0, '0, BUSY, '0, 0);
    chk("to_active", 32'(active_out), 32'd1);
    step(0, 0, '0, ALL_E, '0, 0);
    step(0, 0, '0, ALL_E, '0, 0);
    step(0, 0, '0, BUSY, '0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, '0, ALL_E, '0, 0);
    chk("still_active", 32'(present_state), 32'(STATE_ACTIVE));
    step(0, 0, '0, ALL_E, '0, 0);
    chk("idle_return", 32'(present_state), 32'(STATE_IDLE));

    // Error capture and accumulation.
    step(0, 0, '0, BUSY, '0, 0);
    step(0, 0, '0, BUSY, 5'b00100, 0);
    chk("err_first", 32'(err_src), 32'h04);
    step(0, 0, '0, BUSY, 5'b00001, 0);
    chk("err_accum", 32'(err_src), 32'h05);
    step(0, 0, '0, ALL_E, '0, 0);

    // Error exit: clear (and clear beating a new error) or stay until reset.
    step(0, 0, 20'h13579, ALL_E, 5'b00010, 1);
`ifdef SM_ERR_CLEAR_EN
    chk("err_clear", 32'(present_state), 32'(STATE_INIT));
`else
    chk("err_stays", 32'(present_state), 32'(STATE_ERROR));
`endif
    step(1, 0, '0, ALL_E, '0, 0);
    chk("err_reset", 32'(present_state), 32'(STATE_RESET));

    // Error and activity together in IDLE go to ERROR.
    step(0, 0, 20'h2468A, ALL_E, '0, 0);
    step(0, 1, 20'h2468A, ALL_E, '0, 0);
    step(0, 0, '0, 5'b01111, 5'b10000, 0);
    chk("simul_err", 32'(present_state), 32'(STATE_ERROR));
    step(1, 0, '0, ALL_E, '0, 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic          r, i, ec;
      logic [NF-1:0] em, er;
      logic [TB-1:0] th;
      r  = ($urandom_range(0, 39) == 0);
      i  = ($urandom_range(0, 3) == 0);
      ec = ($urandom_range(0, 7) == 0);
      th = TB'($urandom);
      em = ($urandom_range(0, 2) != 0) ? ALL_E : NF'($urandom);
      er = ($urandom_range(0, 15) == 0) ? NF'($urandom) : '0;
      step(r, i, th, em, er, ec);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
